// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU op codes,
// datapath mux selects and the opcode/funct values the decoder recognises.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_IRQ = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_RTYPE = 3'b001,
        ALU_SLT   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_OR    = 3'b101
    } alu_op_t;

    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_JR     = 3'b011;
    localparam logic [2:0] PC_EPC    = 3'b101;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_MEM = 2'b00;
    localparam logic [1:0] M2R_ALU = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_ERET  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ERET = 6'h18;

    // Shifts take their A operand from the shamt field rather than rs.
    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and handshakes in,
// mux selects and write enables out.
interface mc_control_fsm_if #(
    parameter int ALUOP_W = 4
);
    logic [5:0]         OpCode;
    logic [5:0]         Funct;
    logic               mem_ready;
    logic               irq;

    logic               PCWrite;
    logic               PCWriteCond;
    logic               BranchNe;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic               ExtOp;
    logic               LuiOp;
    logic               EPCWrite;
    logic [1:0]         MemtoReg;
    logic [1:0]         RegDst;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic               irq_ack;
    logic               illegal_op;
    logic [2:0]         state_o;

    modport master (
        input  OpCode, Funct, mem_ready, irq,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, ExtOp, LuiOp, EPCWrite, MemtoReg, RegDst, ALUSrcA,
               ALUSrcB, PCSource, ALUOp, irq_ack, illegal_op, state_o
    );

    modport slave (
        output OpCode, Funct, mem_ready, irq,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, ExtOp, LuiOp, EPCWrite, MemtoReg, RegDst, ALUSrcA,
               ALUSrcB, PCSource, ALUOp, irq_ack, illegal_op, state_o
    );
endinterface

// File: rtl/mc_alu_op_dec.sv
// ALUOp decoder: ADD everywhere except S_EX, where the instruction picks the op.
// The top bit always carries OpCode[0] (signed/unsigned hint for the ALU).
module mc_alu_op_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  state_t             state,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    output logic [ALUOP_W-1:0] ALUOp
);
    alu_op_t op;

    always_comb begin
        op = ALU_ADD;
        if (state == S_EX) begin
            case (OpCode)
                OP_RTYPE:          op = (Funct == FN_JR || Funct == FN_JALR) ? ALU_ADD : ALU_RTYPE;
                OP_SLTI, OP_SLTIU: op = ALU_SLT;
                OP_ANDI:           op = ALU_AND;
                OP_ORI:            op = ALU_OR;
                OP_BEQ, OP_BNE:    op = ALU_SUB;
                default:           op = ALU_ADD;
            endcase
        end
        ALUOp              = '0;
        ALUOp[2:0]         = op;
        ALUOp[ALUOP_W-1]   = OpCode[0];
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM with memory wait states, bne/ori/eret and a
// single-level interrupt that saves EPC.
//
//   state | meaning
//   S_IF  | fetch, or divert to S_IRQ on a pending irq
//   S_ID  | decode, branch target computed in ALU
//   S_EX  | execute / branch / jump / eret / illegal detect
//   S_MEM | lw/sw data access, held until mem_ready
//   S_WB  | register file write-back
//   S_IRQ | save EPC, jump to exception vector
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int         ALUOP_W    = 4,
    parameter bit         MEM_HS     = 1'b1,
    parameter bit         ENABLE_IRQ = 1'b1,
    parameter logic [2:0] VEC_SEL    = 3'b100
) (
    input  logic                  clk,
    input  logic                  reset,
    mc_control_fsm_if.master      bus
);
    state_t state, state_nx;
    logic   in_isr, in_isr_nx;
    logic   rdy;

    assign rdy         = MEM_HS ? bus.mem_ready : 1'b1;
    assign bus.state_o = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IF;
            in_isr <= 1'b0;
        end else begin
            state  <= state_nx;
            in_isr <= ENABLE_IRQ ? in_isr_nx : 1'b0;
        end
    end

    mc_alu_op_dec #(.ALUOP_W(ALUOP_W)) u_alu_op_dec (
        .state  (state),
        .OpCode (bus.OpCode),
        .Funct  (bus.Funct),
        .ALUOp  (bus.ALUOp)
    );

    always_comb begin
        state_nx        = state;
        in_isr_nx       = in_isr;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ExtOp       = 1'b0;
        bus.LuiOp       = 1'b0;
        bus.EPCWrite    = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.RegDst      = 2'b00;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 3'b000;
        bus.irq_ack     = 1'b0;
        bus.illegal_op  = 1'b0;

        case (state)
            S_IF: begin
                if (ENABLE_IRQ && bus.irq && !in_isr) begin
                    state_nx = S_IRQ;
                end else begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    if (rdy) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_nx    = S_ID;
                    end
                end
            end
            S_ID: begin
                bus.ALUSrcB = 2'b11;
                bus.ExtOp   = 1'b1;
                state_nx    = S_EX;
            end
            S_EX: begin
                state_nx = S_IF;
                case (bus.OpCode)
                    OP_RTYPE: begin
                        if (bus.Funct == FN_JR || bus.Funct == FN_JALR) begin
                            bus.PCSource = PC_JR;
                            bus.PCWrite  = 1'b1;
                            if (bus.Funct == FN_JALR) begin
                                bus.RegWrite = 1'b1;
                                bus.RegDst   = RD_RD;
                                bus.MemtoReg = M2R_PC;
                            end
                        end else begin
                            bus.ALUSrcA = is_shift(bus.Funct) ? 2'b10 : 2'b01;
                            state_nx    = S_WB;
                        end
                    end
                    OP_LW, OP_SW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_LUI: begin
                        bus.ALUSrcA = 2'b01;
                        bus.ALUSrcB = 2'b10;
                        bus.ExtOp   = (bus.OpCode != OP_ANDI) && (bus.OpCode != OP_ORI);
                        bus.LuiOp   = (bus.OpCode == OP_LUI);
                        state_nx    = (bus.OpCode == OP_LW || bus.OpCode == OP_SW) ? S_MEM : S_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        bus.ALUSrcA     = 2'b01;
                        bus.PCSource    = PC_BRANCH;
                        bus.PCWriteCond = 1'b1;
                        bus.BranchNe    = (bus.OpCode == OP_BNE);
                    end
                    OP_J, OP_JAL: begin
                        bus.PCSource = PC_JUMP;
                        bus.PCWrite  = 1'b1;
                        if (bus.OpCode == OP_JAL) begin
                            bus.RegWrite = 1'b1;
                            bus.RegDst   = RD_RA;
                            bus.MemtoReg = M2R_PC;
                        end
                    end
                    OP_ERET: begin
                        if (bus.Funct == FN_ERET) begin
                            bus.PCSource = PC_EPC;
                            bus.PCWrite  = 1'b1;
                            in_isr_nx    = 1'b0;
                        end else begin
                            bus.illegal_op = 1'b1;
                        end
                    end
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            S_MEM: begin
                bus.IorD     = 1'b1;
                bus.ALUSrcA  = 2'b01;
                bus.ALUSrcB  = 2'b10;
                bus.MemRead  = (bus.OpCode == OP_LW);
                bus.MemWrite = (bus.OpCode == OP_SW);
                if (rdy) begin
                    state_nx = (bus.OpCode == OP_LW) ? S_WB : S_IF;
                end
            end
            S_WB: begin
                bus.RegWrite = 1'b1;
                if (bus.OpCode == OP_LW) begin
                    bus.RegDst   = RD_RT;
                    bus.MemtoReg = M2R_MEM;
                end else if (bus.OpCode == OP_RTYPE) begin
                    bus.RegDst   = RD_RD;
                    bus.MemtoReg = M2R_ALU;
                end else begin
                    bus.RegDst   = RD_RT;
                    bus.MemtoReg = M2R_ALU;
                end
                state_nx = S_IF;
            end
            S_IRQ: begin
                bus.EPCWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.PCSource = VEC_SEL;
                bus.irq_ack  = 1'b1;
                in_isr_nx    = 1'b1;
                state_nx     = S_IF;
            end
            default: state_nx = S_IF;
        endcase
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a cycle-by-cycle vector table plus
// hand-written reset and ALUOp sequences.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       BranchNe;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegWrite;
        logic       ExtOp;
        logic       LuiOp;
        logic       EPCWrite;
        logic       irq_ack;
        logic       illegal_op;
        logic [1:0] MemtoReg;
        logic [1:0] RegDst;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] PCSource;
        logic [2:0] alu;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       irq;
        logic [2:0] st;
        ctrl_t      exp;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t vecs[$];

    mc_control_fsm_if #(.ALUOP_W(4)) bus ();

    mc_control_fsm #(
        .ALUOP_W    (4),
        .MEM_HS     (1'b1),
        .ENABLE_IRQ (1'b1),
        .VEC_SEL    (3'b100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic ctrl_t get_ctrl();
        ctrl_t c;
        c.PCWrite     = bus.PCWrite;
        c.PCWriteCond = bus.PCWriteCond;
        c.BranchNe    = bus.BranchNe;
        c.IorD        = bus.IorD;
        c.MemRead     = bus.MemRead;
        c.MemWrite    = bus.MemWrite;
        c.IRWrite     = bus.IRWrite;
        c.RegWrite    = bus.RegWrite;
        c.ExtOp       = bus.ExtOp;
        c.LuiOp       = bus.LuiOp;
        c.EPCWrite    = bus.EPCWrite;
        c.irq_ack     = bus.irq_ack;
        c.illegal_op  = bus.illegal_op;
        c.MemtoReg    = bus.MemtoReg;
        c.RegDst      = bus.RegDst;
        c.ALUSrcA     = bus.ALUSrcA;
        c.ALUSrcB     = bus.ALUSrcB;
        c.PCSource    = bus.PCSource;
        c.alu         = bus.ALUOp[2:0];
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                       input logic irq, input logic [2:0] st, input ctrl_t e);
        vec_t v;
        v.op = op; v.fn = fn; v.rdy = rdy; v.irq = irq; v.st = st; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance one clock.
    task automatic run_row(input vec_t v, input int idx);
        ctrl_t got;
        bus.OpCode    = v.op;
        bus.Funct     = v.fn;
        bus.mem_ready = v.rdy;
        bus.irq       = v.irq;
        #2;
        got = get_ctrl();
        tests++;
        if (bus.state_o !== v.st || got !== v.exp) begin
            fails++;
            $display("FAIL row%0d: got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                     idx, bus.state_o, got, v.st, v.exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ctrl_t c_ifr, c_ifw, c_id, c_none, c_exi, c_wbi, c_wbr, c_irq, c_eret, c_exr;
        vec_t  v;

        tests = 0;
        fails = 0;

        c_ifr  = '{PCWrite:1'b1, IRWrite:1'b1, MemRead:1'b1, ALUSrcB:2'b01, default:'0};
        c_ifw  = '{MemRead:1'b1, ALUSrcB:2'b01, default:'0};
        c_id   = '{ALUSrcB:2'b11, ExtOp:1'b1, default:'0};
        c_none = '0;
        c_exi  = '{ALUSrcA:2'b01, ALUSrcB:2'b10, ExtOp:1'b1, default:'0};
        c_wbi  = '{RegWrite:1'b1, MemtoReg:2'b01, default:'0};
        c_wbr  = '{RegWrite:1'b1, MemtoReg:2'b01, RegDst:2'b01, default:'0};
        c_exr  = '{ALUSrcA:2'b01, alu:3'b001, default:'0};
        c_irq  = '{EPCWrite:1'b1, PCWrite:1'b1, PCSource:3'b100, irq_ack:1'b1, default:'0};
        c_eret = '{PCWrite:1'b1, PCSource:3'b101, default:'0};

        // lw, zero waits
        add(6'h23, 6'h00, 1, 0, 0, c_ifr);
        add(6'h23, 6'h00, 1, 0, 1, c_id);
        add(6'h23, 6'h00, 1, 0, 2, c_exi);
        add(6'h23, 6'h00, 1, 0, 3, '{IorD:1'b1, MemRead:1'b1, ALUSrcA:2'b01, ALUSrcB:2'b10, default:'0});
        add(6'h23, 6'h00, 1, 0, 4, '{RegWrite:1'b1, default:'0});
        // two fetch waits, then bne
        add(6'h05, 6'h00, 0, 0, 0, c_ifw);
        add(6'h05, 6'h00, 0, 0, 0, c_ifw);
        add(6'h05, 6'h00, 1, 0, 0, c_ifr);
        add(6'h05, 6'h00, 1, 0, 1, c_id);
        add(6'h05, 6'h00, 1, 0, 2, '{PCWriteCond:1'b1, BranchNe:1'b1, PCSource:3'b001, ALUSrcA:2'b01, alu:3'b011, default:'0});
        // beq
        add(6'h04, 6'h00, 1, 0, 0, c_ifr);
        add(6'h04, 6'h00, 1, 0, 1, c_id);
        add(6'h04, 6'h00, 1, 0, 2, '{PCWriteCond:1'b1, PCSource:3'b001, ALUSrcA:2'b01, alu:3'b011, default:'0});
        // ori
        add(6'h0d, 6'h00, 1, 0, 0, c_ifr);
        add(6'h0d, 6'h00, 1, 0, 1, c_id);
        add(6'h0d, 6'h00, 1, 0, 2, '{ALUSrcA:2'b01, ALUSrcB:2'b10, alu:3'b101, default:'0});
        add(6'h0d, 6'h00, 1, 0, 4, c_wbi);
        // lui
        add(6'h0f, 6'h00, 1, 0, 0, c_ifr);
        add(6'h0f, 6'h00, 1, 0, 1, c_id);
        add(6'h0f, 6'h00, 1, 0, 2, '{ALUSrcA:2'b01, ALUSrcB:2'b10, ExtOp:1'b1, LuiOp:1'b1, default:'0});
        add(6'h0f, 6'h00, 1, 0, 4, c_wbi);
        // slti
        add(6'h0a, 6'h00, 1, 0, 0, c_ifr);
        add(6'h0a, 6'h00, 1, 0, 1, c_id);
        add(6'h0a, 6'h00, 1, 0, 2, '{ALUSrcA:2'b01, ALUSrcB:2'b10, ExtOp:1'b1, alu:3'b010, default:'0});
        add(6'h0a, 6'h00, 1, 0, 4, c_wbi);
        // andi
        add(6'h0c, 6'h00, 1, 0, 0, c_ifr);
        add(6'h0c, 6'h00, 1, 0, 1, c_id);
        add(6'h0c, 6'h00, 1, 0, 2, '{ALUSrcA:2'b01, ALUSrcB:2'b10, alu:3'b100, default:'0});
        add(6'h0c, 6'h00, 1, 0, 4, c_wbi);
        // add (R-type)
        add(6'h00, 6'h20, 1, 0, 0, c_ifr);
        add(6'h00, 6'h20, 1, 0, 1, c_id);
        add(6'h00, 6'h20, 1, 0, 2, c_exr);
        add(6'h00, 6'h20, 1, 0, 4, c_wbr);
        // sll
        add(6'h00, 6'h00, 1, 0, 0, c_ifr);
        add(6'h00, 6'h00, 1, 0, 1, c_id);
        add(6'h00, 6'h00, 1, 0, 2, '{ALUSrcA:2'b10, alu:3'b001, default:'0});
        add(6'h00, 6'h00, 1, 0, 4, c_wbr);
        // jr
        add(6'h00, 6'h08, 1, 0, 0, c_ifr);
        add(6'h00, 6'h08, 1, 0, 1, c_id);
        add(6'h00, 6'h08, 1, 0, 2, '{PCWrite:1'b1, PCSource:3'b011, default:'0});
        // jalr
        add(6'h00, 6'h09, 1, 0, 0, c_ifr);
        add(6'h00, 6'h09, 1, 0, 1, c_id);
        add(6'h00, 6'h09, 1, 0, 2, '{PCWrite:1'b1, PCSource:3'b011, RegWrite:1'b1, RegDst:2'b01, MemtoReg:2'b10, default:'0});
        // j
        add(6'h02, 6'h00, 1, 0, 0, c_ifr);
        add(6'h02, 6'h00, 1, 0, 1, c_id);
        add(6'h02, 6'h00, 1, 0, 2, '{PCWrite:1'b1, PCSource:3'b010, default:'0});
        // jal
        add(6'h03, 6'h00, 1, 0, 0, c_ifr);
        add(6'h03, 6'h00, 1, 0, 1, c_id);
        add(6'h03, 6'h00, 1, 0, 2, '{PCWrite:1'b1, PCSource:3'b010, RegWrite:1'b1, RegDst:2'b10, MemtoReg:2'b10, default:'0});
        // illegal opcode
        add(6'h3f, 6'h00, 1, 0, 0, c_ifr);
        add(6'h3f, 6'h00, 1, 0, 1, c_id);
        add(6'h3f, 6'h00, 1, 0, 2, '{illegal_op:1'b1, default:'0});
        // sw with two data waits
        add(6'h2b, 6'h00, 1, 0, 0, c_ifr);
        add(6'h2b, 6'h00, 1, 0, 1, c_id);
        add(6'h2b, 6'h00, 1, 0, 2, c_exi);
        add(6'h2b, 6'h00, 0, 0, 3, '{IorD:1'b1, MemWrite:1'b1, ALUSrcA:2'b01, ALUSrcB:2'b10, default:'0});
        add(6'h2b, 6'h00, 0, 0, 3, '{IorD:1'b1, MemWrite:1'b1, ALUSrcA:2'b01, ALUSrcB:2'b10, default:'0});
        add(6'h2b, 6'h00, 1, 0, 3, '{IorD:1'b1, MemWrite:1'b1, ALUSrcA:2'b01, ALUSrcB:2'b10, default:'0});
        // irq rises during add; taken only at the next fetch, with mem_ready also high
        add(6'h00, 6'h20, 1, 0, 0, c_ifr);
        add(6'h00, 6'h20, 1, 1, 1, c_id);
        add(6'h00, 6'h20, 1, 1, 2, c_exr);
        add(6'h00, 6'h20, 1, 1, 4, c_wbr);
        add(6'h10, 6'h18, 1, 1, 0, c_none);
        add(6'h10, 6'h18, 1, 1, 5, c_irq);
        // still high but masked in the handler; eret unmasks, so it re-enters
        add(6'h10, 6'h18, 1, 1, 0, c_ifr);
        add(6'h10, 6'h18, 1, 1, 1, c_id);
        add(6'h10, 6'h18, 1, 1, 2, c_eret);
        add(6'h10, 6'h18, 1, 1, 0, c_none);
        add(6'h10, 6'h18, 1, 1, 5, c_irq);
        add(6'h10, 6'h18, 1, 0, 0, c_ifr);
        add(6'h10, 6'h18, 1, 0, 1, c_id);
        add(6'h10, 6'h18, 1, 0, 2, c_eret);

        // reset state: outputs show a stalled fetch
        reset         = 1'b1;
        bus.OpCode    = 6'h00;
        bus.Funct     = 6'h00;
        bus.mem_ready = 1'b0;
        bus.irq       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {29'd0, bus.state_o}, 32'd0);
        chk("reset_ctrl", {5'd0, get_ctrl()}, {5'd0, c_ifw});
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i], i);
        end

        // full ALUOp width for ori: top bit carries OpCode[0]
        v = '{op:6'h0d, fn:6'h00, rdy:1'b1, irq:1'b0, st:3'd0, exp:c_ifr};
        run_row(v, 1000);
        v.st = 3'd1; v.exp = c_id;
        run_row(v, 1001);
        #2;
        chk("ori_aluop", {28'd0, bus.ALUOp}, 32'hd);
        chk("ori_state", {29'd0, bus.state_o}, 32'd2);
        @(posedge clk);
        #1;
        v.st = 3'd4; v.exp = c_wbi;
        run_row(v, 1002);

        // async reset while sw is stalled in S_MEM
        v = '{op:6'h2b, fn:6'h00, rdy:1'b1, irq:1'b0, st:3'd0, exp:c_ifr};
        run_row(v, 1100);
        v.st = 3'd1; v.exp = c_id;
        run_row(v, 1101);
        v.st = 3'd2; v.exp = c_exi;
        run_row(v, 1102);
        bus.mem_ready = 1'b0;
        #2;
        chk("mem_pre_state", {29'd0, bus.state_o}, 32'd3);
        chk("mem_pre_write", {31'd0, bus.MemWrite}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_state", {29'd0, bus.state_o}, 32'd0);
        chk("rst_async_memwrite", {31'd0, bus.MemWrite}, 32'd0);
        chk("rst_async_memread", {31'd0, bus.MemRead}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        v = '{op:6'h23, fn:6'h00, rdy:1'b1, irq:1'b0, st:3'd0, exp:c_ifr};
        run_row(v, 1200);
        v.st = 3'd1; v.exp = c_id;
        run_row(v, 1201);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
